// File: rtl/random_pkg.sv
// Shared types and constants for the random shuffler: FSM states and the LFSR seed/taps.
package random_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One right-shifting Galois step; a nonzero state never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/random_shuffler_lfsr16.sv
// Free-running 16-bit Galois LFSR, reseeded by synchronous active-low reset.
module lfsr16
  import random_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/random_shuffler.sv
// Emits N_STEPS LFSR-derived nibbles per start, each interval INT_INC longer than the last.
// Build option RANDOM_NO_REPEAT_EN: a value equal to the current output is bumped by one.
module random_shuffler
  import random_pkg::*;
#(
  parameter int unsigned BASE_INT = 1000000,
  parameter int unsigned INT_INC  = 500000,
  parameter int unsigned N_STEPS  = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic [3:0] o_random_out,
  output logic       o_valid,
  output logic       o_done,
  output logic       o_busy
);

  localparam logic [31:0] BASE_W  = 32'(BASE_INT);
  localparam logic [31:0] INC_W   = 32'(INT_INC);
  localparam logic [7:0]  STEPS_W = 8'(N_STEPS);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] interval_q, interval_d;
  logic [7:0]  step_q, step_d;
  logic [3:0]  out_q, out_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [15:0] lfsr_state;
  logic        unused_lfsr_hi;
  logic [3:0]  next_value;
  logic        update;
  logic        last;

  lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_state (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:4];

`ifdef RANDOM_NO_REPEAT_EN
  assign next_value = (lfsr_state[3:0] == out_q) ? lfsr_state[3:0] + 4'd1 : lfsr_state[3:0];
`else
  assign next_value = lfsr_state[3:0];
`endif

  assign update = (state_q == RUN) && (timer_q == interval_q - 32'd1);
  assign last   = update && (step_q + 8'd1 == STEPS_W);

  // A start always wins over the timer bookkeeping, but never cancels a due update.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    interval_d = interval_q;
    step_d     = step_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = RUN;
          timer_d    = 32'd0;
          step_d     = 8'd0;
          interval_d = BASE_W;
        end
      end
      RUN: begin
        timer_d = timer_q + 32'd1;
        if (update) begin
          out_d      = next_value;
          valid_d    = 1'b1;
          step_d     = step_q + 8'd1;
          interval_d = interval_q + INC_W;
          timer_d    = 32'd0;
        end
        if (last && !i_start) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        if (i_start) begin
          timer_d    = 32'd0;
          step_d     = 8'd0;
          interval_d = BASE_W;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      timer_q    <= 32'd0;
      interval_q <= BASE_W;
      step_q     <= 8'd0;
      out_q      <= 4'd0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      interval_q <= interval_d;
      step_q     <= step_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_random_out = out_q;
  assign o_valid      = valid_q;
  assign o_done       = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_random_shuffler.sv
// Self-checking bench for random_shuffler with BASE_INT=4, INT_INC=2, N_STEPS=3.
`timescale 1ns/1ps
module tb_random_shuffler;

  localparam int BASE = 4;
  localparam int INC  = 2;
  localparam int NST  = 3;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef RANDOM_NO_REPEAT_EN
  localparam bit NO_REP = 1'b1;
`else
  localparam bit NO_REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] out;
  logic       valid, done, busy;
  int         n_checks = 0;
  int         n_fail = 0;

  random_shuffler #(.BASE_INT(BASE), .INT_INC(INC), .N_STEPS(NST)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_random_out (out),
    .o_valid      (valid),
    .o_done       (done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  function automatic logic [3:0] pick(input logic [3:0] nib, input logic [3:0] prev);
    return (NO_REP && nib == prev) ? nib + 4'd1 : nib;
  endfunction

  // Event-time reference model: each value is due at an absolute edge count.
  int          cyc = 0, m_due = 0, m_ival = 0, m_step = 0;
  bit          m_run = 0, m_valid = 0, m_done = 0, m_busy = 0;
  logic [15:0] m_lfsr = SEED, m_prev = SEED;
  logic [3:0]  m_out = 4'd0;

  initial forever begin
    @(posedge clk);
    m_prev = m_lfsr;
    m_valid = 0;
    m_done = 0;
    if (!rst_n) begin
      m_lfsr = SEED; m_out = 4'd0; m_run = 0; m_busy = 0; m_step = 0;
    end else begin
      m_busy = m_run;
      m_lfsr = adv(m_lfsr, 1);
      if (m_run && cyc == m_due) begin
        m_valid = 1;
        m_out = pick(m_prev[3:0], m_out);
        m_step++;
        m_ival += INC;
        m_due = cyc + m_ival;
        if (m_step == NST && !start) begin m_done = 1; m_run = 0; end
      end
      if (start) begin m_run = 1; m_step = 0; m_ival = BASE; m_due = cyc + BASE; end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) step();
    n_checks += 4;
    if (out !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_out: got %0h want 0", out); end
    if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b want 0", valid); end
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || valid !== 1'b0)
        begin n_fail++; $display("[TB] FAIL reset_start_ignored cyc %0d: busy=%0b valid=%0b want 0 0", c, busy, valid); end
    end
  endtask

  task automatic test_single_shuffle();
    logic [3:0] exp_out;
    bit ev, ed, eb;
    do_reset();
    exp_out = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      step();
      ev = (c == 4 || c == 10 || c == 18); ed = (c == 18); eb = (c <= 18);
      if (ev) exp_out = pick(m_prev[3:0], exp_out);
      n_checks += 4;
      if (valid !== ev) begin n_fail++; $display("[TB] FAIL single_valid cyc %0d: got %0b want %0b", c, valid, ev); end
      if (done !== ed) begin n_fail++; $display("[TB] FAIL single_done cyc %0d: got %0b want %0b", c, done, ed); end
      if (busy !== eb) begin n_fail++; $display("[TB] FAIL single_busy cyc %0d: got %0b want %0b", c, busy, eb); end
      if (out !== exp_out) begin n_fail++; $display("[TB] FAIL single_value cyc %0d: got %0h want %0h", c, out, exp_out); end
    end
  endtask

  task automatic test_restart();
    logic [3:0] exp_out;
    bit ev, ed, eb;
    do_reset();
    exp_out = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      start = (c == 6);
      step();
      start = 1'b0;
      ev = (c == 4 || c == 10 || c == 16 || c == 24); ed = (c == 24); eb = (c <= 24);
      if (ev) exp_out = pick(m_prev[3:0], exp_out);
      n_checks += 4;
      if (valid !== ev) begin n_fail++; $display("[TB] FAIL restart_valid cyc %0d: got %0b want %0b", c, valid, ev); end
      if (done !== ed) begin n_fail++; $display("[TB] FAIL restart_done cyc %0d: got %0b want %0b", c, done, ed); end
      if (busy !== eb) begin n_fail++; $display("[TB] FAIL restart_busy cyc %0d: got %0b want %0b", c, busy, eb); end
      if (out !== exp_out) begin n_fail++; $display("[TB] FAIL restart_value cyc %0d: got %0h want %0h", c, out, exp_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_out;
    bit ev;
    do_reset();
    exp_out = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      start = (c == 18);
      step();
      start = 1'b0;
      ev = (c == 4 || c == 10 || c == 18 || c == 22 || c == 28);
      if (ev) exp_out = pick(m_prev[3:0], exp_out);
      n_checks += 4;
      if (valid !== ev) begin n_fail++; $display("[TB] FAIL b2b_valid cyc %0d: got %0b want %0b", c, valid, ev); end
      if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_done cyc %0d: got %0b want 0", c, done); end
      if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy cyc %0d: got %0b want 1", c, busy); end
      if (out !== exp_out) begin n_fail++; $display("[TB] FAIL b2b_value cyc %0d: got %0h want %0h", c, out, exp_out); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_out;
    bit ev, eb;
    do_reset();
    exp_out = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rst_n = (c != 7);
      step();
      rst_n = 1'b1;
      ev = (c == 4); eb = (c <= 6);
      if (ev) exp_out = pick(m_prev[3:0], exp_out);
      if (c == 7) exp_out = 4'd0;
      n_checks += 4;
      if (valid !== ev) begin n_fail++; $display("[TB] FAIL midrst_valid cyc %0d: got %0b want %0b", c, valid, ev); end
      if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done cyc %0d: got %0b want 0", c, done); end
      if (busy !== eb) begin n_fail++; $display("[TB] FAIL midrst_busy cyc %0d: got %0b want %0b", c, busy, eb); end
      if (out !== exp_out) begin n_fail++; $display("[TB] FAIL midrst_value cyc %0d: got %0h want %0h", c, out, exp_out); end
    end
  endtask

  // Holding start keeps restarting, so the update lands on an LFSR state of our choosing.
  task automatic test_no_repeat();
    logic [3:0]  exp_out;
    logic [15:0] fut;
    int          guard;
    do_reset();
    exp_out = 4'd0;
    for (int pass = 0; pass < 2; pass++) begin
      guard = 0;
      start = 1'b1;
      fut = adv(m_lfsr, 4);
      while (fut[3:0] != 4'hF && guard < 500) begin
        step();
        guard++;
        fut = adv(m_lfsr, 4);
      end
      n_checks++;
      if (guard >= 500) begin n_fail++; $display("[TB] FAIL norep_search pass %0d: got no 4'hF nibble in %0d cycles want one", pass, guard); end
      step();
      start = 1'b0;
      repeat (4) step();
      exp_out = pick(4'hF, exp_out);
      n_checks += 2;
      if (valid !== 1'b1) begin n_fail++; $display("[TB] FAIL norep_valid pass %0d: got %0b want 1", pass, valid); end
      if (out !== exp_out) begin n_fail++; $display("[TB] FAIL norep_value pass %0d: got %0h want %0h", pass, out, exp_out); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 99) < 4);
      rst_n = !($urandom_range(0, 999) < 3);
      step();
      n_checks += 4;
      if (valid !== m_valid) begin n_fail++; $display("[TB] FAIL rand_valid cyc %0d: got %0b want %0b", c, valid, m_valid); end
      if (done !== m_done) begin n_fail++; $display("[TB] FAIL rand_done cyc %0d: got %0b want %0b", c, done, m_done); end
      if (busy !== m_busy) begin n_fail++; $display("[TB] FAIL rand_busy cyc %0d: got %0b want %0b", c, busy, m_busy); end
      if (out !== m_out) begin n_fail++; $display("[TB] FAIL rand_value cyc %0d: got %0h want %0h", c, out, m_out); end
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_single_shuffle();
    test_restart();
    test_back_to_back();
    test_mid_reset();
    test_no_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
